rptr_empty_level: RTL and testbench
===================================

// Module: rptr_empty_level
// PURPOSE
//  Read-side pointer/flag controller for the async video FIFO; successor to the basic read-pointer/empty block.
//  Adds an internal N-stage wptr synchronizer, a fill-level count, a programmable almost-empty flag and an underflow strobe.
//  Sits in the read clock domain between the dual-port RAM read address and the downstream consumer (scanout/blitter).
// PARAMETERS
//  ADDRSIZE     8  RAM address width; FIFO depth = 2**ADDRSIZE; pointers are ADDRSIZE+1 bits
//  SYNC_STAGES  2  flops in the wptr gray synchronizer; legal values >= 2
// PORTS
//  rclk       in   1           read-domain clock
//  rrst       in   1           asynchronous, active-high reset
//  rinc       in   1           read request; honoured only when rempty==0
//  wptr       in   ADDRSIZE+1  gray write pointer, asynchronous to rclk
//  ae_thresh  in   ADDRSIZE+1  almost-empty threshold (level, words)
//  raddr      out  ADDRSIZE    binary RAM read address
//  rptr       out  ADDRSIZE+1  gray read pointer, to write-domain synchronizer
//  rempty     out  1           FIFO empty
//  raempty    out  1           level <= ae_thresh
//  rcount     out  ADDRSIZE+1  words available, 0..2**ADDRSIZE
//  rundflow   out  1           one-cycle pulse: read attempted while empty
// BEHAVIOUR
//  Reset (async assert, sync release to rclk): rbin=0, rptr=0, all sync flops=0, rempty=1, raempty=1, rcount=0, rundflow=0.
//  Synchronizer: wptr -> SYNC_STAGES flops -> rq_wptr; no logic between stages.
//  rbinnext = rbin + (rinc & ~rempty); rgraynext = (rbinnext>>1) ^ rbinnext; both registered each rclk into rbin/rptr.
//  raddr = rbin[ADDRSIZE-1:0], combinational from register; the RAM sees the new address in the cycle after rinc.
//  rempty <= (rgraynext == rq_wptr).
//  rq_wbin = gray2bin(rq_wptr) (combinational); lvl_next = rq_wbin - rbinnext, modulo 2**(ADDRSIZE+1).
//  rcount <= lvl_next; raempty <= (lvl_next <= ae_thresh). Invariant: rcount==0 iff rempty==1.
//  rundflow <= rinc & rempty; the pointer does not move and the flags keep their existing behaviour.
//  Latency: one write becomes visible on rempty/rcount SYNC_STAGES+1 rclk edges after wptr changes.
//  Pop on the last word: the pop edge sets rempty=1 and rcount=0 together.
//  Read and a newly arriving write in the same cycle: lvl_next uses both, so the net level change is 0.
//  Wrap-around: binary and gray pointers wrap modulo 2**(ADDRSIZE+1); the MSB difference distinguishes full from empty.
//  rcount is correct across the wrap, and reaches 2**ADDRSIZE when the FIFO is full.
//  ae_thresh is sampled every cycle; a change shows on raempty at the next edge.
//  ae_thresh >= 2**ADDRSIZE holds raempty=1 permanently.
//  Reset mid-operation: all outputs return to their reset values immediately.
//  The write side must be reset in the same window; stale wptr is flushed through the synchronizer.
//  After reset, rempty stays 1 until a new write propagates.
//  Multi-bit wptr is safe only because it is gray-coded; the block performs no binary-domain crossing.
// STRUCTURE
//  Package fifo_pkg: functions bin2gray()/gray2bin() parameterised by width; ptr width constant ADDRSIZE+1.
//  Sub-module sync_gray_ptr #(WIDTH, STAGES): the reset-to-zero flop chain for wptr.
//  It is reused by the write side for rptr.
//  All remaining logic is in this module: pointer regs, flag regs, level subtractor.
// TESTING (ADDRSIZE=4, SYNC_STAGES=2 unless noted)
//  1 Reset: assert rrst mid-run with rcount=5 -> rempty=1, raempty=1, rcount=0, rptr=0 within the reset cycle, without waiting for an rclk edge.
//  2 Latency: wptr gray 0->1 at edge 0 -> rempty falls and rcount=1 at edge 3, not earlier.
//  3 Fill to 16, drain with rinc held -> rcount 16,15..1,0.
//    rempty=1 on the edge that pops the last word; raddr walks 0..15.
//  4 Wrap: 40 write/read cycles -> binary pointer wraps past 31.
//    rcount is never >16 and never negative, and matches a scoreboard every cycle.
//  5 Underflow: rinc=1 while empty for 3 cycles -> rundflow=1 for 3 cycles, rptr unchanged, rempty stays 1.
//  6 Threshold: ae_thresh=3, level 4 -> raempty=0; pop one -> raempty=1.
//    ae_thresh=16 -> raempty=1 at full; repeat with SYNC_STAGES=3, where latency becomes 4.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: pointer geometry defaults and gray/binary conversion.
package fifo_pkg;

  // Default RAM address width; pointers carry one extra wrap bit.
  localparam int unsigned FIFO_ADDRSIZE = 8;
  localparam int unsigned FIFO_PTR_W    = FIFO_ADDRSIZE + 1;

  // Conversion functions work on a wide container. Callers zero-extend any
  // pointer up to this width and truncate the result back down. Zero upper
  // bits do not disturb the lower bits in either direction, so one function
  // serves every pointer width up to GRAY_MAX_W.
  localparam int unsigned GRAY_MAX_W = 32;

  typedef logic [GRAY_MAX_W-1:0] gray_vec_t;

  // Binary to reflected gray code.
  function automatic gray_vec_t bin2gray(input gray_vec_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Reflected gray code to binary: each bit is the XOR of all gray bits at or above it.
  function automatic gray_vec_t gray2bin(input gray_vec_t gray);
    gray_vec_t bin;
    bin = '0;
    bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage : fifo_pkg

// File: rtl/sync_gray_ptr.sv
// Multi-flop synchronizer for a gray-coded FIFO pointer crossing into this clock domain.
// Used for wptr on the read side and for rptr on the write side.
module sync_gray_ptr #(
  parameter int unsigned WIDTH  = 9,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Stage 0 is the metastability-catching flop; only the last stage is used.
  logic [STAGES-1:0][WIDTH-1:0] stage_q;

  // Plain flop chain, cleared by reset so a stale pointer cannot survive it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[STAGES-2:0], d};
    end
  end

  assign q = stage_q[STAGES-1];

endmodule : sync_gray_ptr

// File: rtl/rptr_empty_level.sv
// Read-side pointer and flag controller for the async video FIFO.
// Holds the read pointer and derives empty, fill level, almost-empty and
// underflow from a synchronized copy of the gray write pointer.
// rrst is expected to be released synchronously to rclk by the reset tree.
module rptr_empty_level
  import fifo_pkg::*;
#(
  parameter int unsigned ADDRSIZE    = FIFO_ADDRSIZE,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   wptr,
  input  logic [ADDRSIZE:0]   ae_thresh,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                raempty,
  output logic [ADDRSIZE:0]   rcount,
  output logic                rundflow
);

  localparam int unsigned PTR_W = ADDRSIZE + 1;

  logic [PTR_W-1:0] rq_wptr;
  logic [PTR_W-1:0] rq_wbin;
  logic [PTR_W-1:0] rbin;
  logic [PTR_W-1:0] rbinnext;
  logic [PTR_W-1:0] rgraynext;
  logic [PTR_W-1:0] lvl_next;
  logic             rd_ok;

  // Bring the gray write pointer into the read clock domain.
  sync_gray_ptr #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_sync_wptr (
    .clk (rclk),
    .rst (rrst),
    .d   (wptr),
    .q   (rq_wptr)
  );

  // A read only advances the pointer when there is data to read.
  assign rd_ok     = rinc & ~rempty;
  assign rbinnext  = rbin + PTR_W'(rd_ok);
  assign rgraynext = PTR_W'(bin2gray(GRAY_MAX_W'(rbinnext)));

  // Level uses the post-read pointer, so a read and an arriving write
  // in the same cycle cancel. Modulo arithmetic handles the wrap bit.
  assign rq_wbin  = PTR_W'(gray2bin(GRAY_MAX_W'(rq_wptr)));
  assign lvl_next = rq_wbin - rbinnext;

  // RAM address is the low bits of the registered binary pointer.
  assign raddr = rbin[ADDRSIZE-1:0];

  // Binary and gray read pointers.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin <= '0;
      rptr <= '0;
    end else begin
      rbin <= rbinnext;
      rptr <= rgraynext;
    end
  end

  // Empty, level and almost-empty flags, all from the same next-state level.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rempty  <= 1'b1;
      raempty <= 1'b1;
      rcount  <= '0;
    end else begin
      rempty  <= (rgraynext == rq_wptr);
      raempty <= (lvl_next <= ae_thresh);
      rcount  <= lvl_next;
    end
  end

  // One-cycle strobe for a read request that arrived while empty.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rundflow <= 1'b0;
    end else begin
      rundflow <= rinc & rempty;
    end
  end

endmodule : rptr_empty_level

// File: tb/tb_rptr_empty_level.sv
// Self-checking bench: two instances (2- and 3-stage synchronizer) share one
// stimulus stream and are each compared every cycle against a level model.
module tb_rptr_empty_level;

  localparam int unsigned A     = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned MODN  = 32;

  logic         rclk = 1'b0;
  logic         rrst = 1'b0;
  logic         rinc;
  logic [A:0]   wptr;
  logic [A:0]   ae_thresh;

  logic [A-1:0] d0_raddr, d1_raddr;
  logic [A:0]   d0_rptr, d1_rptr, d0_rcount, d1_rcount;
  logic         d0_rempty, d1_rempty, d0_raempty, d1_raempty, d0_rundflow, d1_rundflow;

  int unsigned  n_checks = 0;
  int unsigned  n_fail   = 0;
  bit           chk_en   = 1'b0;

  // Reference state: total words written / read (mod 32) and derived flags.
  int unsigned  w_bin;
  int unsigned  stg [2] = '{2, 3};
  int unsigned  m_rd [2];
  int unsigned  m_lvl [2];
  bit           m_empty [2];
  bit           m_aempty [2];
  bit           m_undf [2];
  int unsigned  whist [$];
  int unsigned  k;
  int unsigned  used;
  bit           pop;

  always #5 rclk = ~rclk;

  rptr_empty_level #(.ADDRSIZE(A), .SYNC_STAGES(2)) dut0 (
    .rclk(rclk), .rrst(rrst), .rinc(rinc), .wptr(wptr), .ae_thresh(ae_thresh),
    .raddr(d0_raddr), .rptr(d0_rptr), .rempty(d0_rempty), .raempty(d0_raempty),
    .rcount(d0_rcount), .rundflow(d0_rundflow)
  );

  rptr_empty_level #(.ADDRSIZE(A), .SYNC_STAGES(3)) dut1 (
    .rclk(rclk), .rrst(rrst), .rinc(rinc), .wptr(wptr), .ae_thresh(ae_thresh),
    .raddr(d1_raddr), .rptr(d1_rptr), .rempty(d1_rempty), .raempty(d1_raempty),
    .rcount(d1_rcount), .rundflow(d1_rundflow)
  );

  function automatic int unsigned gray(input int unsigned b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the read side sees the write count sampled stg edges ago.
  always @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      for (int i = 0; i < 2; i++) begin
        m_rd[i] = 0; m_lvl[i] = 0; m_empty[i] = 1'b1; m_aempty[i] = 1'b1; m_undf[i] = 1'b0;
      end
      whist.delete();
      k = 0;
    end else begin
      whist.push_back(w_bin);
      for (int i = 0; i < 2; i++) begin
        used        = (k >= stg[i]) ? whist[k - stg[i]] : 0;
        pop         = rinc && !m_empty[i];
        m_undf[i]   = rinc && m_empty[i];
        m_rd[i]     = (m_rd[i] + pop) % MODN;
        m_lvl[i]    = (used + MODN - m_rd[i]) % MODN;
        m_empty[i]  = (m_lvl[i] == 0);
        m_aempty[i] = (m_lvl[i] <= ae_thresh);
      end
      k++;
    end
  end

  task automatic cmp_inst(input int i, input logic emp, input logic aemp, input logic undf,
                          input logic [A:0] cnt, input logic [A:0] ptr, input logic [A-1:0] addr);
    chk($sformatf("d%0d rempty", i),   emp,  m_empty[i]);
    chk($sformatf("d%0d raempty", i),  aemp, m_aempty[i]);
    chk($sformatf("d%0d rundflow", i), undf, m_undf[i]);
    chk($sformatf("d%0d rcount", i),   cnt,  m_lvl[i]);
    chk($sformatf("d%0d rptr", i),     ptr,  gray(m_rd[i]));
    chk($sformatf("d%0d raddr", i),    addr, m_rd[i] % DEPTH);
    chk($sformatf("d%0d empty_iff_zero", i), (cnt == 0), emp);
    chk($sformatf("d%0d count_le_depth", i), (cnt <= DEPTH), 1);
  endtask

  // Per-cycle comparison on the falling edge, away from register updates.
  always @(negedge rclk) begin
    if (chk_en) begin
      cmp_inst(0, d0_rempty, d0_raempty, d0_rundflow, d0_rcount, d0_rptr, d0_raddr);
      cmp_inst(1, d1_rempty, d1_raempty, d1_rundflow, d1_rcount, d1_rptr, d1_raddr);
    end
  end

  // True occupancy must stay within the FIFO depth for both instances.
  function automatic bit room();
    for (int i = 0; i < 2; i++) begin
      if (((w_bin + MODN - m_rd[i]) % MODN) >= DEPTH) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic cyc(input bit ri, input bit wr);
    @(negedge rclk);
    rinc = ri;
    if (wr && room()) w_bin = (w_bin + 1) % MODN;
    wptr = (A+1)'(gray(w_bin));
  endtask

  task automatic after_edge();
    @(posedge rclk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rinc = 1'b0; wptr = '0; ae_thresh = 5'd3; w_bin = 0;
    #1 rrst = 1'b1;
    #1;
    chk("reset rempty", d0_rempty, 1);
    chk("reset raempty", d0_raempty, 1);
    chk("reset rcount", d0_rcount, 0);
    chk("reset rptr", d0_rptr, 0);
    chk_en = 1'b1;
    repeat (3) cyc(0, 0);
    @(negedge rclk) rrst = 1'b0;
    repeat (4) cyc(0, 0);

    // Latency of a single write through the synchronizer.
    cyc(0, 1);
    for (int e = 1; e <= 4; e++) begin
      after_edge();
      chk($sformatf("latency d0 rempty e%0d", e), d0_rempty, (e >= 3) ? 0 : 1);
      chk($sformatf("latency d1 rempty e%0d", e), d1_rempty, (e >= 4) ? 0 : 1);
      if (e == 3) chk("latency d0 rcount", d0_rcount, 1);
      if (e == 4) chk("latency d1 rcount", d1_rcount, 1);
    end

    // Fill to full, then drain with rinc held.
    @(negedge rclk) ae_thresh = 5'd16;
    repeat (15) cyc(0, 1);
    repeat (5) cyc(0, 0);
    chk("full d0 rcount", d0_rcount, 16);
    chk("full d1 rcount", d1_rcount, 16);
    chk("full d0 raempty", d0_raempty, 1);
    chk("full d1 raempty", d1_raempty, 1);
    chk("full d0 rempty", d0_rempty, 0);
    for (int j = 1; j <= 16; j++) begin
      cyc(1, 0);
      chk($sformatf("drain raddr %0d", j), d0_raddr, j - 1);
      after_edge();
      chk($sformatf("drain rcount %0d", j), d0_rcount, 16 - j);
      chk($sformatf("drain rempty %0d", j), d0_rempty, (j == 16) ? 1 : 0);
    end

    // Underflow: pointer frozen at 16 (gray 24), strobe each attempt.
    for (int j = 0; j < 3; j++) begin
      cyc(1, 0);
      after_edge();
      chk("underflow rundflow", d0_rundflow, 1);
      chk("underflow rptr", d0_rptr, 24);
      chk("underflow rempty", d0_rempty, 1);
    end
    cyc(0, 0);
    after_edge();
    chk("underflow strobe clears", d0_rundflow, 0);

    // Almost-empty threshold.
    @(negedge rclk) ae_thresh = 5'd3;
    repeat (4) cyc(0, 1);
    repeat (6) cyc(0, 0);
    chk("thresh level4 rcount", d0_rcount, 4);
    chk("thresh level4 raempty", d0_raempty, 0);
    cyc(1, 0);
    after_edge();
    chk("thresh level3 rcount", d0_rcount, 3);
    chk("thresh level3 raempty", d0_raempty, 1);
    cyc(0, 0);
    @(negedge rclk) ae_thresh = 5'd2;
    after_edge();
    chk("thresh change raempty", d0_raempty, 0);

    // Randomized traffic with wrap-around, write-heavy then read-heavy.
    for (int n = 0; n < 900; n++) begin
      int unsigned wp;
      wp = (n < 450) ? 70 : 35;
      if ($urandom_range(0, 19) == 0) begin
        @(negedge rclk) ae_thresh = (A+1)'($urandom_range(0, 31));
      end
      cyc($urandom_range(0, 99) < 50, $urandom_range(0, 99) < wp);
    end

    // Mid-run reset with five words held.
    repeat (25) cyc(1, 0);
    repeat (3) cyc(0, 0);
    repeat (5) cyc(0, 1);
    repeat (6) cyc(0, 0);
    chk("pre-reset d0 rcount", d0_rcount, 5);
    @(posedge rclk);
    #3;
    rrst = 1'b1; w_bin = 0; wptr = '0; rinc = 1'b0;
    #1;
    chk("midreset d0 rempty", d0_rempty, 1);
    chk("midreset d0 raempty", d0_raempty, 1);
    chk("midreset d0 rcount", d0_rcount, 0);
    chk("midreset d0 rptr", d0_rptr, 0);
    chk("midreset d1 rcount", d1_rcount, 0);
    repeat (3) cyc(0, 0);
    @(negedge rclk) rrst = 1'b0;
    repeat (4) cyc(0, 0);
    chk("post-reset d0 rempty", d0_rempty, 1);
    chk("post-reset d1 rempty", d1_rempty, 1);
    for (int n = 0; n < 200; n++) begin
      cyc($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 55);
    end
    repeat (6) cyc(0, 0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_rptr_empty_level
